mul_ra_controller: RTL and testbench



---
 rtl/mul_ra_controller_pkg.sv | 17 +
 rtl/mul_ra_controller_if.sv | 28 ++
 rtl/mul_ra_controller_iter_cntr.sv | 34 +++
 rtl/mul_ra_controller.sv | 150 +++++++++++++++
 tb/tb_mul_ra_controller.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mul_ra_controller_pkg.sv
// Shared types and constants for the repeated-addition multiplier controller.
package mul_ra_pkg;

    localparam int   CNT_W_DEF = 16;
    localparam logic OP_A      = 1'b0;
    localparam logic OP_B      = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_A = 3'd1,
        ST_LOAD_B = 3'd2,
        ST_ADD    = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERR    = 3'd5
    } state_t;

endpackage

// File: rtl/mul_ra_controller_if.sv
// Host/datapath handshake bundle between the controller and its surroundings.
interface mul_ra_controller_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic             abort;
    logic             eqz;
    logic             LdA;
    logic             LdB;
    logic             LdP;
    logic             clrP;
    logic             decB;
    logic             op_sel;
    logic             busy;
    logic             done;
    logic             err;
    logic [CNT_W-1:0] iter_count;

    modport master (
        output start, abort, eqz,
        input  LdA, LdB, LdP, clrP, decB, op_sel, busy, done, err, iter_count
    );

    modport slave (
        input  start, abort, eqz,
        output LdA, LdB, LdP, clrP, decB, op_sel, busy, done, err, iter_count
    );
endinterface

// File: rtl/mul_ra_controller_iter_cntr.sv
// Saturating addition counter; o_term flags that the watchdog limit is reached.
module mul_ra_iter_cntr #(
    parameter int          CNT_W    = 16,
    parameter int unsigned MAX_ITER = 65535
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_count,
    output logic             o_term
);
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_ITER);

    logic [CNT_W-1:0] r_count;
    logic             w_term;

    assign w_term  = (r_count == MAX_C);
    assign o_count = r_count;
    assign o_term  = w_term;

    // Count enabled additions; never step past the limit so the value cannot wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && !w_term) begin
            r_count <= r_count + CNT_W'(1'b1);
        end else begin
            r_count <= r_count;
        end
    end
endmodule

// File: rtl/mul_ra_controller.sv
// Sequencing FSM for the multiply-by-repeated-addition datapath.
module mul_ra_controller
    import mul_ra_pkg::*;
#(
    parameter int          CNT_W    = CNT_W_DEF,
    parameter int unsigned MAX_ITER = 65535
) (
    input  logic                clk,
    input  logic                rst,
    mul_ra_controller_if.slave  bus
);
    state_t           r_state;
    logic             r_lda;
    logic             r_ldb;
    logic             r_clrp;
    logic             r_op_sel;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic             w_accept;
    logic             w_add;
    logic             w_term;
    logic [CNT_W-1:0] w_count;

    assign w_accept = (r_state == ST_IDLE) && bus.start && !bus.abort;
    // Add strobes look at eqz in the same cycle so no addition happens once B is zero.
    assign w_add    = (r_state == ST_ADD) && !bus.eqz && !w_term;

    mul_ra_iter_cntr #(
        .CNT_W    (CNT_W),
        .MAX_ITER (MAX_ITER)
    ) u_iter_cntr (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_accept),
        .i_en    (w_add),
        .o_count (w_count),
        .o_term  (w_term)
    );

    // State register together with the registered Moore-style outputs of the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_lda    <= 1'b0;
            r_ldb    <= 1'b0;
            r_clrp   <= 1'b0;
            r_op_sel <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else if (bus.abort && (r_state != ST_IDLE)) begin
            r_state  <= ST_IDLE;
            r_lda    <= 1'b0;
            r_ldb    <= 1'b0;
            r_clrp   <= 1'b0;
            r_op_sel <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= r_err;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state  <= ST_LOAD_A;
                        r_lda    <= 1'b1;
                        r_op_sel <= OP_A;
                        r_busy   <= 1'b1;
                        r_err    <= 1'b0;
                    end else begin
                        r_state  <= ST_IDLE;
                        r_lda    <= 1'b0;
                        r_op_sel <= 1'b0;
                        r_busy   <= 1'b0;
                        r_err    <= r_err;
                    end
                    r_ldb  <= 1'b0;
                    r_clrp <= 1'b0;
                    r_done <= 1'b0;
                end
                ST_LOAD_A: begin
                    r_state  <= ST_LOAD_B;
                    r_lda    <= 1'b0;
                    r_ldb    <= 1'b1;
                    r_clrp   <= 1'b1;
                    r_op_sel <= OP_B;
                    r_busy   <= 1'b1;
                    r_done   <= 1'b0;
                end
                ST_LOAD_B: begin
                    r_state  <= ST_ADD;
                    r_lda    <= 1'b0;
                    r_ldb    <= 1'b0;
                    r_clrp   <= 1'b0;
                    r_op_sel <= 1'b0;
                    r_busy   <= 1'b1;
                    r_done   <= 1'b0;
                end
                ST_ADD: begin
                    if (bus.eqz) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end else if (w_term) begin
                        r_state <= ST_ERR;
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                    end else begin
                        r_state <= ST_ADD;
                        r_done  <= 1'b0;
                    end
                    r_lda    <= 1'b0;
                    r_ldb    <= 1'b0;
                    r_clrp   <= 1'b0;
                    r_op_sel <= 1'b0;
                    r_busy   <= 1'b1;
                end
                ST_DONE, ST_ERR: begin
                    r_state  <= ST_IDLE;
                    r_lda    <= 1'b0;
                    r_ldb    <= 1'b0;
                    r_clrp   <= 1'b0;
                    r_op_sel <= 1'b0;
                    r_busy   <= 1'b0;
                    r_done   <= 1'b0;
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_lda    <= 1'b0;
                    r_ldb    <= 1'b0;
                    r_clrp   <= 1'b0;
                    r_op_sel <= 1'b0;
                    r_busy   <= 1'b0;
                    r_done   <= 1'b0;
                    r_err    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.LdA        = r_lda;
    assign bus.LdB        = r_ldb;
    assign bus.clrP       = r_clrp;
    assign bus.op_sel     = r_op_sel;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.err        = r_err;
    assign bus.LdP        = w_add;
    assign bus.decB       = w_add;
    assign bus.iter_count = w_count;
endmodule

// File: tb/tb_mul_ra_controller.sv
// Scoreboard bench: behavioural datapath around the controller, results checked on done.
module tb_mul_ra_controller;
    localparam int CNT_W    = 16;
    localparam int MAX_ITER = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mul_ra_controller_if #(.CNT_W(CNT_W)) bus ();

    mul_ra_controller #(.CNT_W(CNT_W), .MAX_ITER(MAX_ITER)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int cyc;
        int p;
        int iter;
        int err;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;
    int   ldp_cnt  = 0;
    int   viol     = 0;

    logic [15:0] host_a  = 16'd0;
    logic [15:0] host_b  = 16'd0;
    logic [15:0] dp_a    = 16'd0;
    logic [15:0] dp_b    = 16'd1;
    logic [15:0] dp_p    = 16'd0;
    logic [15:0] data_in;

    assign data_in = bus.op_sel ? host_b : host_a;
    assign bus.eqz = (dp_b == 16'd0);

    // Datapath model
    always @(posedge clk) begin
        if (bus.LdA) dp_a <= data_in;
        if (bus.LdB) dp_b <= data_in;
        else if (bus.decB) dp_b <= dp_b - 16'd1;
        if (bus.clrP) dp_p <= 16'd0;
        else if (bus.LdP) dp_p <= dp_p + dp_a;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Monitor: strobe sanity every cycle, scoreboard pop on done
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.LdA) ldp_cnt = 0;
            if (bus.LdP) begin
                ldp_cnt++;
                if (bus.eqz) viol++;
            end
            if ((32'(bus.LdA) + 32'(bus.LdB) + 32'(bus.LdP)) > 32'd1) viol++;
            if (bus.done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("done_cycle", cyc, e.cyc);
                    chk("product", 32'(dp_p), e.p);
                    chk("iter_count", 32'(bus.iter_count), e.iter);
                    chk("err", 32'(bus.err), e.err);
                    chk("add_pulses", ldp_cnt, e.iter);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    // Drive operands and start at the current negedge; returns the cycle index.
    task automatic start_op(input int a, input int b, input bit push, output int s);
        exp_t e;
        int   n;
        host_a    = 16'(a);
        host_b    = 16'(b);
        bus.start = 1'b1;
        s = cyc;
        if (push) begin
            n      = (b > MAX_ITER) ? MAX_ITER : b;
            e.cyc  = s + 4 + n;
            e.p    = a * n;
            e.iter = n;
            e.err  = (b > MAX_ITER) ? 1 : 0;
            q.push_back(e);
        end
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (q.size() != 0 && k < 200) begin
            tick();
            k++;
        end
        if (q.size() != 0) begin
            chk("done_timeout", q.size(), 32'd0);
            q.delete();
        end
        tick();
    endtask

    task automatic check_idle_outputs(input string tag);
        chk(tag, {23'd0, bus.LdA, bus.LdB, bus.LdP, bus.clrP, bus.decB,
                  bus.op_sel, bus.busy, bus.done, bus.err}, 32'd0);
        chk({tag, "_iter"}, 32'(bus.iter_count), 32'd0);
    endtask

    initial begin
        int s;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        rst       = 1'b1;
        repeat (3) tick();
        check_idle_outputs("reset");
        rst = 1'b0;
        tick();

        // 5 x 3 with explicit load-phase timing
        start_op(5, 3, 1'b1, s);
        tick();
        bus.start = 1'b0;
        chk("t1_lda", {30'd0, bus.LdA, bus.op_sel}, 32'd2);
        tick();
        chk("t2_ldb_clrp", {29'd0, bus.LdB, bus.clrP, bus.op_sel}, 32'd7);
        wait_done();

        // 7 x 0: ADD lasts one cycle, no additions
        start_op(7, 0, 1'b1, s);
        tick();
        bus.start = 1'b0;
        wait_done();

        // watchdog: 2 x 10 stops after MAX_ITER additions
        start_op(2, 10, 1'b1, s);
        tick();
        bus.start = 1'b0;
        wait_done();
        repeat (3) tick();
        chk("err_sticky", {30'd0, bus.err, bus.busy}, 32'd2);

        // abort and start together in IDLE: stays idle
        bus.start = 1'b1;
        bus.abort = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk("abort_start_idle", {30'd0, bus.busy, bus.err}, 32'd1);
        tick();

        // 3 x 6 aborted in the 2nd ADD cycle
        start_op(3, 6, 1'b0, s);
        tick();
        bus.start = 1'b0;
        chk("err_cleared", 32'(bus.err), 32'd0);
        while (cyc < s + 4) tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("abort_busy", {30'd0, bus.busy, bus.done}, 32'd0);
        chk("abort_iter", 32'(bus.iter_count), 32'd2);
        tick();
        start_op(6, 2, 1'b1, s);
        tick();
        bus.start = 1'b0;
        wait_done();

        // 1 x 4 (exactly MAX_ITER adds) with a start pulse during ADD that must be ignored
        start_op(1, 4, 1'b1, s);
        tick();
        bus.start = 1'b0;
        while (cyc < s + 4) tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done();
        repeat (2) tick();
        chk("no_queued_start", 32'(bus.busy), 32'd0);

        // rst mid-ADD of a 2 x 5 run
        start_op(2, 5, 1'b0, s);
        tick();
        bus.start = 1'b0;
        while (cyc < s + 4) tick();
        chk("pre_rst_busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        tick();
        check_idle_outputs("rst_mid_add");
        rst = 1'b0;
        repeat (2) tick();
        chk("post_rst_idle", 32'(bus.busy), 32'd0);

        // start held high across 2 x 2 then 4 x 1
        start_op(2, 2, 1'b1, s);
        tick();
        tick();
        tick();
        host_a = 16'd4;
        host_b = 16'd1;
        begin
            exp_t e;
            e.cyc = s + 12; e.p = 4; e.iter = 1; e.err = 0;
            q.push_back(e);
        end
        while (cyc < s + 7) tick();
        chk("held_idle_gap", 32'(bus.busy), 32'd0);
        tick();
        chk("held_second_lda", 32'(bus.LdA), 32'd1);
        bus.start = 1'b0;
        wait_done();

        chk("strobe_violations", viol, 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
